trace_frame_tx: RTL and testbench

- Consumer end of the trace path. Accepts finished trace records (packed trace_format) from the trace unit's writeback stage.
- Buffers the records in a FIFO and transmits each one as a byte-framed packet on a valid/ready byte stream toward the host link (UART/JTAG bridge).
- The trace unit cannot be stalled, so on overflow records are dropped, counted, and the loss is flagged in the next frame sent.

---
 rtl/trace_frame_tx.sv | 176 +++++++++++++++++
 tb/tb_trace_frame_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_frame_tx.sv
// trace_frame_tx
// Consumer end of the trace path. Finished trace records are buffered in a
// small FIFO and sent to the host link as byte-framed packets:
//    header, seq, payload byte 0..N-1 (little-endian), chk
// where chk is the XOR of seq and all payload bytes. The trace unit cannot be
// stalled, so a record that finds the FIFO full is dropped and counted, and
// the next frame carries LOSS_BYTE as its header instead of SYNC_BYTE.
//
// Ports:
//    clk            single clock, rising edge
//    rst            asynchronous reset, active low
//    trace_valid_i  one-cycle strobe, trace_data_i holds a new record
//    trace_data_i   packed trace record
//    tx_valid_o     tx_data_o holds a frame byte
//    tx_data_o      frame byte
//    tx_last_o      high on the checksum byte (last byte of a frame)
//    tx_ready_i     byte accepted when tx_valid_o && tx_ready_i
//    fifo_level_o   registered FIFO occupancy
//    drop_count_o   dropped records since reset, saturating
//
// state | meaning
// IDLE  | nothing to send; pops the FIFO head as soon as it is non-empty
// HDR   | presenting the header byte (sync or loss)
// SEQ   | presenting the sequence number
// PAY   | presenting payload bytes 0..N-1 from the shift register
// CHK   | presenting the checksum; pops the next record directly if present

module trace_frame_tx #(
   parameter int          TRACE_WIDTH  = 128,
   parameter int          BUFFER_DEPTH = 8,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter logic [7:0]  LOSS_BYTE    = 8'hA6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            trace_valid_i,
   input  logic [TRACE_WIDTH-1:0]          trace_data_i,
   output logic                            tx_valid_o,
   output logic [7:0]                      tx_data_o,
   output logic                            tx_last_o,
   input  logic                            tx_ready_i,
   output logic [$clog2(BUFFER_DEPTH):0]   fifo_level_o,
   output logic [15:0]                     drop_count_o
);

   localparam int NB = TRACE_WIDTH / 8;
   localparam int AW = $clog2(BUFFER_DEPTH);
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
   localparam logic [AW:0]   DEPTH     = (AW+1)'(BUFFER_DEPTH);

   typedef enum logic [2:0] {IDLE, HDR, SEQ, PAY, CHK} state_t;

   state_t                 state_q, state_d;
   logic [TRACE_WIDTH-1:0] mem [BUFFER_DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [AW:0]            count_q;
   logic [TRACE_WIDTH-1:0] shift_q;
   logic [7:0]             hdr_q, seq_q, chk_q;
   logic [CW-1:0]          byte_cnt_q;
   logic                   loss_q;
   logic                   pop, push, drop, hs, empty, full;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH);
   assign hs    = tx_valid_o && tx_ready_i;

   // A full FIFO still accepts a record when its head leaves in the same cycle.
   assign push  = trace_valid_i && (!full || pop);
   assign drop  = trace_valid_i && !push;

   assign fifo_level_o = count_q;

   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      tx_valid_o = 1'b0;
      tx_last_o  = 1'b0;
      tx_data_o  = 8'h00;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = HDR;
            end
         end
         HDR: begin
            tx_valid_o = 1'b1;
            tx_data_o  = hdr_q;
            if (hs) state_d = SEQ;
         end
         SEQ: begin
            tx_valid_o = 1'b1;
            tx_data_o  = seq_q;
            if (hs) state_d = PAY;
         end
         PAY: begin
            tx_valid_o = 1'b1;
            tx_data_o  = shift_q[7:0];
            if (hs && byte_cnt_q == LAST_BYTE) state_d = CHK;
         end
         CHK: begin
            tx_valid_o = 1'b1;
            tx_last_o  = 1'b1;
            tx_data_o  = chk_q;
            if (hs) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = HDR;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Storage needs no reset; occupancy and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= trace_data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         loss_q       <= 1'b0;
         drop_count_o <= 16'h0000;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
         // A drop in the pop cycle keeps the flag for the following frame.
         if (drop)     loss_q <= 1'b1;
         else if (pop) loss_q <= 1'b0;
         if (drop && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q    <= '0;
         hdr_q      <= 8'h00;
         seq_q      <= 8'h00;
         chk_q      <= 8'h00;
         byte_cnt_q <= '0;
      end else begin
         if (state_q == CHK && hs) seq_q <= seq_q + 8'd1;
         if (pop) begin
            shift_q    <= mem[rd_ptr_q];
            hdr_q      <= loss_q ? LOSS_BYTE : SYNC_BYTE;
            chk_q      <= 8'h00;
            byte_cnt_q <= '0;
         end else if (hs) begin
            if (state_q == SEQ) chk_q <= chk_q ^ seq_q;
            if (state_q == PAY) begin
               chk_q      <= chk_q ^ shift_q[7:0];
               shift_q    <= shift_q >> 8;
               byte_cnt_q <= byte_cnt_q + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_trace_frame_tx.sv
module tb_trace_frame_tx;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         trace_valid_i = 1'b0;
   logic [127:0] trace_data_i = '0;
   logic         tx_valid_o;
   logic [7:0]   tx_data_o;
   logic         tx_last_o;
   logic         tx_ready_i;
   logic [3:0]   fifo_level_o;
   logic [15:0]  drop_count_o;

   trace_frame_tx dut (
      .clk          (clk),
      .rst          (rst),
      .trace_valid_i(trace_valid_i),
      .trace_data_i (trace_data_i),
      .tx_valid_o   (tx_valid_o),
      .tx_data_o    (tx_data_o),
      .tx_last_o    (tx_last_o),
      .tx_ready_i   (tx_ready_i),
      .fifo_level_o (fifo_level_o),
      .drop_count_o (drop_count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [7:0] d; logic l;} exp_t;
   exp_t       exp_q[$];
   int         tests = 0;
   int         fails = 0;
   int         hs_cnt = 0;
   int         gap_cnt = 0;
   int         peak = 0;
   logic [7:0] seq_m = 8'h00;
   bit         ready_rnd = 1'b0;
   bit         ready_hold = 1'b1;
   logic       pv = 1'b0;
   logic [7:0] pd = 8'h00;
   logic       pl = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [127:0] rec(int i);
      logic [31:0] a;
      a = i;
      return {a * 32'd3 + 32'h1111, ~a, a ^ 32'h5A5A5A5A, (a << 4) | 32'h9};
   endfunction

   // Issue one strobe; when keep is set, enqueue the frame it must produce.
   task automatic send(logic [127:0] d, logic [7:0] hdr, bit keep);
      logic [7:0] c;
      logic [7:0] b;
      if (keep) begin
         exp_q.push_back({hdr, 1'b0});
         exp_q.push_back({seq_m, 1'b0});
         c = seq_m;
         for (int k = 0; k < 16; k++) begin
            b = d[8*k +: 8];
            exp_q.push_back({b, 1'b0});
            c = c ^ b;
         end
         exp_q.push_back({c, 1'b1});
         seq_m = seq_m + 8'd1;
      end
      trace_valid_i = 1'b1;
      trace_data_i  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(string name, int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tx_valid_o) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, (exp_q.size() == 0 && !tx_valid_o)}, 32'd1);
   endtask

   initial begin
      tx_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready_i = ready_rnd ? 1'($urandom_range(0, 1)) : ready_hold;
      end
   end

   // Monitor: compares every accepted byte against the scoreboard and
   // checks that a stalled byte holds.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pv = 1'b0;
            continue;
         end
         if (pv) begin
            tests++;
            if (!tx_valid_o || tx_data_o !== pd || tx_last_o !== pl) begin
               fails++;
               $display("FAIL hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                        tx_valid_o, tx_data_o, tx_last_o, pd, pl);
            end
         end
         if (tx_valid_o && tx_ready_i) begin
            hs_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL byte: got unexpected data=%h last=%b", tx_data_o, tx_last_o);
            end else begin
               e = exp_q.pop_front();
               if (tx_data_o !== e.d || tx_last_o !== e.l) begin
                  fails++;
                  $display("FAIL byte: got data=%h last=%b required data=%h last=%b",
                           tx_data_o, tx_last_o, e.d, e.l);
               end
            end
         end
         if (!tx_valid_o && exp_q.size() != 0) gap_cnt++;
         pv = tx_valid_o && !tx_ready_i;
         pd = tx_data_o;
         pl = tx_last_o;
         if (int'(fifo_level_o) > peak) peak = int'(fifo_level_o);
      end
   end

   initial begin
      int n;
      int base;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, tx_valid_o}, 32'd0);
      check("rst_data", {24'd0, tx_data_o}, 32'd0);
      check("rst_last", {31'd0, tx_last_o}, 32'd0);
      check("rst_level", {28'd0, fifo_level_o}, 32'd0);
      check("rst_drop", {16'd0, drop_count_o}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // single record, latency
      send(128'h0F0E0D0C_0B0A0908_07060504_03020100, 8'hA5, 1'b1);
      trace_valid_i = 1'b0;
      check("lat_e", {31'd0, tx_valid_o}, 32'd0);
      @(posedge clk);
      #1;
      check("lat_e1", {31'd0, tx_valid_o}, 32'd1);
      check("lat_hdr", {24'd0, tx_data_o}, 32'hA5);
      wait_drain("drain_single", 200);

      // three back-to-back frames
      peak = 0;
      for (int i = 0; i < 3; i++) send(rec(i), 8'hA5, 1'b1);
      trace_valid_i = 1'b0;
      gap_cnt = 0;
      wait_drain("drain_three", 300);
      check("three_gap", gap_cnt, 32'd0);
      check("three_peak", {31'd0, (peak >= 2 && peak <= 3)}, 32'd1);
      check("three_level", {28'd0, fifo_level_o}, 32'd0);

      // overflow with sink stalled
      ready_hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) send(rec(20 + i), (i == 1) ? 8'hA6 : 8'hA5, i < 9);
      trace_valid_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("ovf_level", {28'd0, fifo_level_o}, 32'd8);
      check("ovf_drop", {16'd0, drop_count_o}, 32'd1);
      ready_hold = 1'b1;
      wait_drain("drain_ovf", 600);
      check("ovf_drop_after", {16'd0, drop_count_o}, 32'd1);

      // random backpressure
      ready_rnd = 1'b1;
      send(rec(40), 8'hA5, 1'b1);
      send(rec(41), 8'hA5, 1'b1);
      trace_valid_i = 1'b0;
      wait_drain("drain_rnd", 1000);
      ready_rnd = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 257 frames, sequence wrap
      for (int i = 0; i < 257; i++) begin
         n = 0;
         while (fifo_level_o >= 4'd6 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
         end
         send(rec(100 + i), 8'hA5, 1'b1);
         trace_valid_i = 1'b0;
      end
      wait_drain("drain_wrap", 2000);
      check("wrap_drop", {16'd0, drop_count_o}, 32'd1);

      // reset mid-payload (payload byte 7 presented)
      base = hs_cnt;
      send(rec(7), 8'hA5, 1'b1);
      trace_valid_i = 1'b0;
      n = 0;
      while (hs_cnt - base < 10 && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("rst_reach_b7", {31'd0, (hs_cnt - base >= 10)}, 32'd1);
      rst = 1'b0;
      #1;
      check("rst_async_valid", {31'd0, tx_valid_o}, 32'd0);
      exp_q.delete();
      seq_m = 8'h00;
      @(posedge clk);
      #1;
      check("rst2_level", {28'd0, fifo_level_o}, 32'd0);
      check("rst2_drop", {16'd0, drop_count_o}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      send(128'h11223344_55667788_99AABBCC_DDEEFF00, 8'hA5, 1'b1);
      trace_valid_i = 1'b0;
      wait_drain("drain_post_rst", 200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
